vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Generates VGA 640x480@60 raster timing from the 25 MHz pixel clock produced by the /2 clock divider.
//  Drives the hsync/vsync pins and supplies the pixel coordinates and video_on flag to the pixel/render stage.
//  Raster position is held in two free-running counters, h_cnt and v_cnt.
//  Every output is registered and coherent with the others in the same cycle.
// PARAMETERS
//  H_ACTIVE   640  visible pixels per line
//  H_FP       16   horizontal front porch, in pixels
//  H_SYNC     96   hsync pulse width, in pixels
//  H_BP       48   horizontal back porch, in pixels
//  V_ACTIVE   480  visible lines per frame
//  V_FP       10   vertical front porch, in lines
//  V_SYNC     2    vsync pulse width, in lines
//  V_BP       33   vertical back porch, in lines
//  SYNC_POL   0    asserted level of hsync/vsync (0 = active-low)
//  CW         10   width of the coordinate counters; must hold H_TOTAL-1 and V_TOTAL-1
// PORTS
//  clk          in   1   pixel clock (25 MHz, from clock_div_2 clk_out)
//  rst_n        in   1   asynchronous reset, active low
//  hsync        out  1   horizontal sync to the VGA connector
//  vsync        out  1   vertical sync to the VGA connector
//  video_on     out  1   1 while (pixel_x,pixel_y) is inside the visible area
//  pixel_x      out  CW  current h_cnt (raw; consumers qualify it with video_on)
//  pixel_y      out  CW  current v_cnt (raw)
//  line_start   out  1   1-cycle pulse when h_cnt==0
//  frame_start  out  1   1-cycle pulse when h_cnt==0 && v_cnt==0
//  frame_cnt    out  8   frame counter (only when VGA_FRAME_CNT_EN is defined)
// BEHAVIOUR
//  Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
//  Horizontal counter:
//   - h_cnt increments every clk edge.
//   - At H_TOTAL-1 it wraps to 0 and v_cnt advances.
//  Vertical counter:
//   - v_cnt wraps from V_TOTAL-1 to 0 on the same edge that h_cnt wraps.
//  Output alignment:
//   - Flags are registered, decoded from next-state counts.
//   - So in any cycle all outputs describe the same (h_cnt,v_cnt). No combinational path to any output.
//  Decode rules:
//   - video_on = (h<H_ACTIVE)&&(v<V_ACTIVE).
//   - hsync = SYNC_POL while H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC (656..751), else ~SYNC_POL.
//   - vsync = SYNC_POL while V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC (490..491) for the whole line, else ~SYNC_POL.
//  Reset (async, rst_n low):
//   - h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1, so pixel_x=799 and pixel_y=524.
//   - hsync=vsync=~SYNC_POL; video_on=0; line_start=0; frame_start=0.
//   - First edge after release moves to (0,0) with video_on=1, line_start=1, frame_start=1.
//  Reset mid-frame: outputs go to their reset values immediately, not at the next edge; the frame is abandoned.
//  After reset release there is no partial frame: the first full frame starts on the first edge after release.
//  Latency: zero; position (x,y) is presented in the cycle its flags are valid.
//  Downstream pixel data needing N pipeline cycles must delay hsync/vsync/video_on by N itself.
// CONFIGURATION
//  VGA_FRAME_CNT_EN defined:
//   - frame_cnt[7:0] is present, reset 0.
//   - Increments on the edge that asserts frame_start, so it reads 1 during the first frame.
//   - Wraps 255->0.
//  VGA_FRAME_CNT_EN undefined: frame_cnt port and register are absent; all other behaviour is identical.
// TESTING
//  1 Reset low 5 cycles -> hsync=vsync=1, video_on=0, pixel=(799,524); 1st edge after release -> (0,0), video_on=1, line_start=frame_start=1.
//  2 Run 2 lines -> hsync low exactly 96 cycles starting at pixel_x=656; line_start period 800 cycles.
//  3 Run 1 frame -> vsync low for 1600 cycles starting at (0,490); frame_start period 420000; video_on high 307200 cycles/frame.
//  4 Check every cycle -> pixel_x wraps 799->0 and pixel_y increments in that same cycle; pixel_y wraps 524->0 with frame_start=1.
//  5 Pull rst_n low at (300,100) between edges -> outputs take reset values before next edge; after release -> frame restarts at (0,0).
//  6 VGA_FRAME_CNT_EN, H_ACTIVE=4/H_FP=H_SYNC=H_BP=1/V_*=1 -> frame_cnt 1..255,0 over 256 frames; undefined build compiles without the port.

Source files
------------

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from vga_timing_gen to the sync pins and the render stage.
// frame_cnt is only carried when VGA_FRAME_CNT_EN is defined.
interface vga_timing_gen_if #(
  parameter int CW = 10
);
  logic          hsync;
  logic          vsync;
  logic          video_on;
  logic [CW-1:0] pixel_x;
  logic [CW-1:0] pixel_y;
  logic          line_start;
  logic          frame_start;
`ifdef VGA_FRAME_CNT_EN
  logic [7:0]    frame_cnt;

  modport master (
    output hsync, vsync, video_on, pixel_x, pixel_y, line_start, frame_start, frame_cnt
  );
  modport slave (
    input  hsync, vsync, video_on, pixel_x, pixel_y, line_start, frame_start, frame_cnt
  );
`else
  modport master (
    output hsync, vsync, video_on, pixel_x, pixel_y, line_start, frame_start
  );
  modport slave (
    input  hsync, vsync, video_on, pixel_x, pixel_y, line_start, frame_start
  );
`endif
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing (640x480@60 default); every output registered from next-state counts, zero latency.
// Free-running, no backpressure. Define VGA_FRAME_CNT_EN to add the 8-bit frame_cnt output.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0,
  parameter int CW       = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  vga_timing_gen_if.master  vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_VIS  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC);

  logic [CW-1:0] h_cnt, v_cnt;
  logic [CW-1:0] h_nxt, v_nxt;
  logic          hsync_q, vsync_q, video_on_q, line_start_q, frame_start_q;
  logic          hsync_d, vsync_d, video_on_d, line_start_d, frame_start_d;

  always_comb begin
    h_nxt = h_cnt + CW'(1);
    v_nxt = v_cnt;
    if (h_cnt == H_LAST) begin
      h_nxt = '0;
      v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + CW'(1);
    end
  end

  // Flags decode the position the counters are about to hold, so they land aligned with it.
  always_comb begin
    hsync_d       = ((h_nxt >= HS_BEG) && (h_nxt < HS_END)) ? SYNC_POL : ~SYNC_POL;
    vsync_d       = ((v_nxt >= VS_BEG) && (v_nxt < VS_END)) ? SYNC_POL : ~SYNC_POL;
    video_on_d    = (h_nxt < H_VIS) && (v_nxt < V_VIS);
    line_start_d  = (h_nxt == '0);
    frame_start_d = (h_nxt == '0) && (v_nxt == '0);
  end

  // Reset parks on the last pixel of the frame so the first edge after release lands on (0,0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt         <= H_LAST;
      v_cnt         <= V_LAST;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      video_on_q    <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_cnt         <= h_nxt;
      v_cnt         <= v_nxt;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.video_on    = video_on_q;
  assign vga.pixel_x     = h_cnt;
  assign vga.pixel_y     = v_cnt;
  assign vga.line_start  = line_start_q;
  assign vga.frame_start = frame_start_q;

`ifdef VGA_FRAME_CNT_EN
  logic [7:0] frame_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= 8'd0;
    end else if (frame_start_d) begin
      frame_cnt_q <= frame_cnt_q + 8'd1;
    end
  end

  assign vga.frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size instance and a tiny active-high-sync instance share clock and reset,
// both compared every cycle against a position model derived from edges counted since reset release.
module tb_vga_timing_gen;

  localparam int SH_A = 8, SH_F = 2, SH_S = 3, SH_B = 2;
  localparam int SV_A = 6, SV_F = 1, SV_S = 2, SV_B = 1;
  localparam int S_FRAME = (SH_A + SH_F + SH_S + SH_B) * (SV_A + SV_F + SV_S + SV_B);
  localparam int D_FRAME = 800 * 525;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int n_chk = 0;
  int n_err = 0;
  int k     = 0;   // active edges since the last reset release

  bit agg_en = 1'b0;
  int hs_cnt = 0, ls_cnt = 0, vo_cnt_s = 0, vs_cnt_s = 0;

  always #5 clk = ~clk;

  vga_timing_gen_if #(.CW(10)) vga_d ();
  vga_timing_gen_if #(.CW(4))  vga_s ();

  vga_timing_gen dut_d (
    .clk   (clk),
    .rst_n (rst_n),
    .vga   (vga_d)
  );

  vga_timing_gen #(
    .H_ACTIVE (SH_A), .H_FP (SH_F), .H_SYNC (SH_S), .H_BP (SH_B),
    .V_ACTIVE (SV_A), .V_FP (SV_F), .V_SYNC (SV_S), .V_BP (SV_B),
    .SYNC_POL (1'b1), .CW (4)
  ) dut_s (
    .clk   (clk),
    .rst_n (rst_n),
    .vga   (vga_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (edge %0d, t=%0t)", tag, obs, exp, k, $time);
    end
  endtask

  // Position index within the frame: reset parks one step before index 0.
  task automatic check_dut(input string nm,
                           input int ha, input int hf, input int hs, input int hb,
                           input int va, input int vf, input int vs, input int vb,
                           input bit pol, input int kk,
                           input logic [31:0] ox, input logic [31:0] oy,
                           input logic ohs, input logic ovs, input logic ovo,
                           input logic ols, input logic ofs);
    int ht, vt, ft, p, x, y;
    bit hs_e, vs_e, vo_e, ls_e, fs_e;
    ht = ha + hf + hs + hb;
    vt = va + vf + vs + vb;
    ft = ht * vt;
    p  = (kk == 0) ? ft - 1 : (kk - 1) % ft;
    x  = p % ht;
    y  = p / ht;
    hs_e = (x >= ha + hf && x < ha + hf + hs) ? pol : !pol;
    vs_e = (y >= va + vf && y < va + vf + vs) ? pol : !pol;
    vo_e = (x < ha) && (y < va);
    ls_e = (kk > 0) && (x == 0);
    fs_e = ls_e && (y == 0);
    chk({nm, ".pixel_x"}, ox, x);
    chk({nm, ".pixel_y"}, oy, y);
    chk({nm, ".hsync"}, {31'd0, ohs}, {31'd0, hs_e});
    chk({nm, ".vsync"}, {31'd0, ovs}, {31'd0, vs_e});
    chk({nm, ".video_on"}, {31'd0, ovo}, {31'd0, vo_e});
    chk({nm, ".line_start"}, {31'd0, ols}, {31'd0, ls_e});
    chk({nm, ".frame_start"}, {31'd0, ofs}, {31'd0, fs_e});
  endtask

`ifdef VGA_FRAME_CNT_EN
  function automatic int fcnt_exp(input int kk, input int ft);
    return (kk == 0) ? 0 : (((kk - 1) / ft) + 1) % 256;
  endfunction
`endif

  task automatic check_now();
    check_dut("d", 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, k,
              32'(vga_d.pixel_x), 32'(vga_d.pixel_y), vga_d.hsync, vga_d.vsync,
              vga_d.video_on, vga_d.line_start, vga_d.frame_start);
    check_dut("s", SH_A, SH_F, SH_S, SH_B, SV_A, SV_F, SV_S, SV_B, 1'b1, k,
              32'(vga_s.pixel_x), 32'(vga_s.pixel_y), vga_s.hsync, vga_s.vsync,
              vga_s.video_on, vga_s.line_start, vga_s.frame_start);
`ifdef VGA_FRAME_CNT_EN
    chk("d.frame_cnt", 32'(vga_d.frame_cnt), fcnt_exp(k, D_FRAME));
    chk("s.frame_cnt", 32'(vga_s.frame_cnt), fcnt_exp(k, S_FRAME));
`endif
  endtask

  // One clock: count the edge if out of reset, then sample on the falling edge.
  task automatic tick();
    @(posedge clk);
    if (rst_n) k++;
    @(negedge clk);
    check_now();
    if (agg_en) begin
      if (k >= 1 && k <= 1600) begin
        hs_cnt += (vga_d.hsync == 1'b0) ? 1 : 0;
        ls_cnt += vga_d.line_start ? 1 : 0;
      end
      if (k >= 1 && k <= S_FRAME) begin
        vo_cnt_s += vga_s.video_on ? 1 : 0;
        vs_cnt_s += (vga_s.vsync == 1'b1) ? 1 : 0;
      end
    end
  endtask

  initial begin
    int d;
    rst_n = 1'b0;
    repeat (5) tick();

    rst_n  = 1'b1;
    agg_en = 1'b1;
    repeat (2400) tick();
    agg_en = 1'b0;
    chk("hsync_low_2_lines", hs_cnt, 192);
    chk("line_starts_2_lines", ls_cnt, 2);
    chk("s.video_on_per_frame", vo_cnt_s, SH_A * SV_A);
    chk("s.vsync_per_frame", vs_cnt_s, SV_S * (SH_A + SH_F + SH_S + SH_B));

    // Asynchronous resets dropped between edges at random raster positions.
    for (int r = 0; r < 8; r++) begin
      repeat ($urandom_range(1, 2000)) tick();
      @(posedge clk);
      if (rst_n) k++;
      d = $urandom_range(1, 3);
      #(d);
      rst_n = 1'b0;
      k     = 0;
      #1;
      check_now();
      repeat ($urandom_range(1, 4)) tick();
      rst_n = 1'b1;
    end

    // Long run on the tiny raster covers frame wrap and the 8-bit frame counter wrap.
    repeat (256 * S_FRAME + 20) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
